// File: rtl/banner_scroller.sv
// Banner window streamer: fetches WIN rows from a registered-address ROM and scrolls the window offset.
// Optional build macro BANNER_SCROLLER_INVERT_EN adds a per-frame row inversion input.
module banner_scroller #(
    parameter int ROW_W       = 57,
    parameter int DEPTH       = 129,
    parameter int ADDR_W      = 8,
    parameter int WIN         = 16,
    parameter int IDX_W       = 4,
    parameter int STEP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              dir,
    input  logic              mode_wrap,
    input  logic              offset_load,
`ifdef BANNER_SCROLLER_INVERT_EN
    input  logic              invert,
`endif
    input  logic [ADDR_W-1:0] offset_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROW_W-1:0]  rom_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [ROW_W-1:0]  row_data,
    output logic [IDX_W-1:0]  row_idx,
    output logic              row_last,
    output logic [ADDR_W-1:0] offset,
    output logic              busy,
    output logic              at_end
);

    localparam int CNT_W = $clog2(STEP_FRAMES + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FWD_LIMIT = ADDR_W'(DEPTH - WIN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(STEP_FRAMES);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  frame_cnt_inc;
    logic [ADDR_W-1:0] step_offset;
    logic              step_at_end;
    logic [ADDR_W-1:0] next_addr;
    logic              start;
    logic              accept;
    logic              frame_done;
`ifdef BANNER_SCROLLER_INVERT_EN
    logic              invert_q;
`endif

    assign start         = (state == IDLE) && frame_start;
    assign accept        = (state == SEND) && row_ready;
    assign frame_done    = accept && (row_idx == LAST_IDX);
    assign frame_cnt_inc = frame_cnt + 1'b1;
    assign next_addr     = (rom_addr == LAST_ROW) ? '0 : rom_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (frame_start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    state_next = SEND;
            SEND:    if (row_ready) state_next = (row_idx == LAST_IDX) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        row_valid = (state == SEND);
        busy      = (state != IDLE);
        row_last  = (state == SEND) && (row_idx == LAST_IDX);
    end

    // One-shot forward clamps offsets loaded beyond the limit back onto it.
    always_comb begin
        step_offset = offset;
        step_at_end = 1'b0;
        if (mode_wrap) begin
            if (!dir) step_offset = (offset == LAST_ROW) ? '0 : offset + 1'b1;
            else      step_offset = (offset == '0) ? LAST_ROW : offset - 1'b1;
        end else begin
            if (!dir) begin
                step_offset = (offset >= FWD_LIMIT) ? FWD_LIMIT : offset + 1'b1;
                step_at_end = (step_offset == FWD_LIMIT);
            end else begin
                step_offset = (offset == '0) ? '0 : offset - 1'b1;
                step_at_end = (step_offset == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset    <= '0;
            at_end    <= 1'b0;
            frame_cnt <= '0;
            rom_addr  <= '0;
            row_idx   <= '0;
            row_data  <= '0;
`ifdef BANNER_SCROLLER_INVERT_EN
            invert_q  <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) && offset_load) begin
                offset <= offset_in;
                at_end <= 1'b0;
            end
            if (start) begin
                rom_addr <= offset_load ? offset_in : offset;
                row_idx  <= '0;
`ifdef BANNER_SCROLLER_INVERT_EN
                invert_q <= invert;
`endif
            end
            if (state == WAIT) begin
`ifdef BANNER_SCROLLER_INVERT_EN
                row_data <= rom_data ^ {ROW_W{invert_q}};
`else
                row_data <= rom_data;
`endif
            end
            if (accept && !frame_done) begin
                row_idx  <= row_idx + 1'b1;
                rom_addr <= next_addr;
            end
            if (frame_done) begin
                row_idx <= '0;
                if (enable) begin
                    if (frame_cnt_inc == CNT_TOP) begin
                        frame_cnt <= '0;
                        offset    <= step_offset;
                        at_end    <= step_at_end;
                    end else begin
                        frame_cnt <= frame_cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller: ROM model, frame streaming, scrolling modes, backpressure, reset.
module tb_banner_scroller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic        dir;
    logic        mode_wrap;
    logic        offset_load;
    logic [7:0]  offset_in;
    logic [7:0]  rom_addr;
    logic [56:0] rom_data;
    logic        row_valid;
    logic        row_ready;
    logic [56:0] row_data;
    logic [3:0]  row_idx;
    logic        row_last;
    logic [7:0]  offset;
    logic        busy;
    logic        at_end;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    banner_scroller #(
        .ROW_W(57), .DEPTH(129), .ADDR_W(8), .WIN(16), .IDX_W(4), .STEP_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .dir(dir), .mode_wrap(mode_wrap), .offset_load(offset_load),
        .offset_in(offset_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_last(row_last), .offset(offset), .busy(busy),
        .at_end(at_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [56:0] pattern(input int unsigned a);
        logic [48:0] hi;
        hi = ~(49'(a) * 49'd1234567);
        return {hi, 8'(a)};
    endfunction

    // External ROM: registered address, data one cycle later.
    always @(posedge clk) rom_data <= pattern(int'(rom_addr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int unsigned off, input bit load,
                             input int unsigned stall_row, input int unsigned stall_len);
        int unsigned waited;
        int unsigned addr;
        logic [56:0] held;
        offset_load = load;
        offset_in   = 8'(off);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        offset_load = 1'b0;
        check("fetch_busy", busy, 1);
        check("fetch_addr", rom_addr, off);
        check("fetch_valid", row_valid, 0);
        for (int i = 0; i < 16; i++) begin
            waited = 0;
            while (!row_valid && waited < 10) begin
                tick();
                waited++;
            end
            addr = (off + i) % 129;
            check("row_gap", waited, 2);
            check("row_valid", row_valid, 1);
            check("row_idx", row_idx, i);
            check("row_last", row_last, (i == 15));
            check("row_addr", rom_addr, addr);
            check("row_data", row_data, pattern(addr));
            if (i == stall_row) begin
                held = pattern(addr);
                row_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    frame_start = (k == 1);
                    tick();
                    frame_start = 1'b0;
                    check("stall_valid", row_valid, 1);
                    check("stall_idx", row_idx, i);
                    check("stall_addr", rom_addr, addr);
                    check("stall_data", row_data, held);
                end
                row_ready = 1'b1;
            end
            tick();
        end
        check("frame_idle", busy, 0);
    endtask

    initial begin
        int unsigned n;
        bit found;
        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; dir = 1'b0; mode_wrap = 1'b1;
        offset_load = 1'b0; offset_in = '0; row_ready = 1'b1;
        tick(); tick();
        check("rst_addr", rom_addr, 0);
        check("rst_valid", row_valid, 0);
        check("rst_data", row_data, 0);
        check("rst_idx", row_idx, 0);
        check("rst_last", row_last, 0);
        check("rst_offset", offset, 0);
        check("rst_busy", busy, 0);
        check("rst_at_end", at_end, 0);
        rst_n = 1'b1;
        tick();

        // Defaults: two frames from offset 0.
        run_frame(0, 0, 99, 0);
        check("def_off1", offset, 0);
        run_frame(0, 0, 99, 0);
        check("def_off2", offset, 1);

        // Forward wrap; load coincident with frame_start.
        run_frame(120, 1, 99, 0);
        check("fw_off1", offset, 120);
        run_frame(120, 0, 99, 0);
        check("fw_off2", offset, 121);
        run_frame(128, 1, 99, 0);
        run_frame(128, 0, 99, 0);
        check("fw_wrap", offset, 0);

        // Backward wrap, then one-shot backward at 0.
        dir = 1'b1;
        run_frame(0, 0, 99, 0);
        run_frame(0, 0, 99, 0);
        check("bw_wrap", offset, 128);
        mode_wrap = 1'b0;
        run_frame(0, 1, 99, 0);
        check("bw_os_end0", at_end, 0);
        run_frame(0, 0, 99, 0);
        check("bw_os_off", offset, 0);
        check("bw_os_end", at_end, 1);

        // One-shot forward from 112.
        dir = 1'b0;
        run_frame(112, 1, 99, 0);
        check("os_clear", at_end, 0);
        run_frame(112, 0, 99, 0);
        check("os_off1", offset, 113);
        check("os_end1", at_end, 1);
        run_frame(113, 0, 99, 0);
        run_frame(113, 0, 99, 0);
        check("os_off2", offset, 113);
        check("os_end2", at_end, 1);
        offset_load = 1'b1; offset_in = 8'd5;
        tick();
        offset_load = 1'b0;
        check("load_off", offset, 5);
        check("load_end", at_end, 0);
        check("load_busy", busy, 0);

        // Disabled scrolling freezes offset.
        enable = 1'b0;
        run_frame(5, 0, 99, 0);
        run_frame(5, 0, 99, 0);
        check("freeze_off", offset, 5);
        enable = 1'b1;

        // Backpressure on row 3.
        run_frame(5, 0, 3, 5);
        check("bp_off", offset, 5);
        tick();
        check("bp_no_restart", busy, 0);

        // Reset during row 7.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            if (row_valid && row_idx == 4'd7) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("reach_row7", found, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", row_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_offset", offset, 0);
        check("mid_rst_idx", row_idx, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run_frame(0, 0, 99, 0);
        check("post_rst_off", offset, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
